// File: rtl/beat_sequencer.sv
`timescale 1ns/1ps
// Beat generator for the hardwired controller: one-hot W1/W2/W3 strobes,
// short/long instruction shaping, stop/step halting and an instruction counter.
module beat_sequencer #(
    parameter int CNT_W = 8
) (
    input  logic             t3,
    input  logic             clr,
    input  logic             qd,
    input  logic             step_mode,
    input  logic             short,
    input  logic             long,
    input  logic             stop,
    output logic             w1,
    output logic             w2,
    output logic             w3,
    output logic             running,
    output logic             instr_done,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [1:0] {W1, W2, W3} beat_t;

    beat_t beat, beat_nxt;
    logic  halted, qd_q;
    logic  qd_rise, eoi, halt_nxt;

    always_comb begin
        qd_rise  = qd & ~qd_q;
        beat_nxt = beat;
        eoi      = 1'b0;
        case (beat)
            W1: begin
                if (short) eoi = 1'b1;
                else       beat_nxt = W2;
            end
            W2: begin
                if (long) beat_nxt = W3;
                else begin
                    beat_nxt = W1;
                    eoi      = 1'b1;
                end
            end
            default: begin
                beat_nxt = W1;
                eoi      = 1'b1;
            end
        endcase
        halt_nxt = stop | (eoi & step_mode);
    end

    // The beat advances even when halting, so resume picks up the following beat.
    always_ff @(negedge t3 or negedge clr) begin
        if (!clr) begin
            beat       <= W1;
            halted     <= 1'b1;
            qd_q       <= 1'b0;
            w1         <= 1'b0;
            w2         <= 1'b0;
            w3         <= 1'b0;
            running    <= 1'b0;
            instr_done <= 1'b0;
            instr_cnt  <= '0;
        end else begin
            qd_q       <= qd;
            instr_done <= 1'b0;
            if (halted) begin
                if (qd_rise) begin
                    halted  <= 1'b0;
                    running <= 1'b1;
                    w1      <= (beat == W1);
                    w2      <= (beat == W2);
                    w3      <= (beat == W3);
                end
            end else begin
                beat    <= beat_nxt;
                halted  <= halt_nxt;
                running <= ~halt_nxt;
                w1      <= (beat_nxt == W1) & ~halt_nxt;
                w2      <= (beat_nxt == W2) & ~halt_nxt;
                w3      <= (beat_nxt == W3) & ~halt_nxt;
                if (eoi) begin
                    instr_cnt  <= instr_cnt + 1'b1;
                    instr_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/beat_sequencer.md
# beat_sequencer

Beat (machine-cycle) generator that sequences the hardwired CPU controller. It produces the one-hot beat signals w1/w2/w3 consumed by the controller, shortens or lengthens each instruction according to the controller's `short`/`long` requests, and pauses on `stop` until the operator presses the start button. It also supports single-step mode and counts completed instructions.

## Interface
Parameters:
- CNT_W, 8, width of the completed-instruction counter.

Ports:
- t3  input  1  clock (beat pulse). All state updates on the falling edge of t3.
- clr  input  1  reset: asynchronous, active-low.
- qd  input  1  start/continue button (level). Only its rising edge, as sampled at falling t3, is acted on.
- step_mode  input  1  1 = halt after every completed instruction.
- short  input  1  from controller; valid in W1: the instruction ends after W1.
- long  input  1  from controller; valid in W2: insert W3.
- stop  input  1  from controller; pause after the current beat.
- w1, w2, w3  output  1 each  beat strobes; at most one high; all 0 while halted.
- running  output  1  1 when not halted.
- instr_done  output  1  high for exactly one t3 period after each end-of-instruction edge.
- instr_cnt  output  CNT_W  completed-instruction count.

## Operation
- Internal state:
  - beat ∈ {W1, W2, W3}
  - halted flag
  - qd_q: last sampled qd.
- Outputs are registered:
  - wN = (beat==WN) & !halted
  - running = !halted
- qd_rise = qd & !qd_q. qd_q updates on every falling t3.
- While halted:
  - qd_rise clears halted; beat is unchanged and resumes at the held beat.
  - All other inputs are ignored.
- While running, the next beat is computed at the falling t3 edge:
  - W1: if short → W1, end of instruction (EOI). Else → W2.
  - W2: if long → W3. Else → W1, EOI.
  - W3: → W1, EOI.
- short is ignored outside W1; long is ignored outside W2.
- Halt conditions, evaluated at the same edge and using the computed next beat:
  - stop=1 → halted=1.
  - EOI & step_mode → halted=1.
  - A halted beat is held and resumes on the next qd_rise.
- On EOI:
  - instr_cnt increments by 1, modulo 2^CNT_W (255 → 0 with default width).
  - instr_done = 1 for the following period; otherwise 0.
- Precedence:
  - short beats stop for next-beat selection; stop still halts.
  - qd_rise while running is ignored.

## Timing
- Reset (clr=0), asynchronous and immediate, including mid-beat:
  - beat=W1, halted=1, qd_q=0
  - w1=w2=w3=0, running=0, instr_done=0, instr_cnt=0
- Release of clr does not start the machine; a qd_rise is required.
- Start latency: qd rises before falling edge n → w1=1 from edge n.
- Instruction lengths in t3 periods:
  - short: 1
  - normal: 2
  - long: 3
- No idle period between instructions.
- stop sampled at edge n:
  - The current beat ends at n; all w are 0 from n.
  - A qd_rise at edge m ≥ n+1 reasserts the next beat from m.
- instr_done and the instr_cnt change appear at the same edge that begins the next beat (or the halt).
- short, long and stop are combinational inputs derived from the current beat outputs. They must be stable before falling t3; no input is registered except qd.

## Test plan
- **Reset and start:** clr=0 mid-W2 → all outputs 0 at once. Release clr, hold qd=0 for 3 edges → stays halted. Raise qd → w1=1 at the next falling edge, running=1.
- **Beat sequences:**
  - short=1 in W1 → w1 stays high, instr_cnt +1 each edge.
  - short=0, long=0 → W1,W2,W1,W2…, instr_cnt +1 every 2 edges.
  - long=1 in W2 → W1,W2,W3,W1.
- **Stop/resume:**
  - stop=1 during W1 of a normal instruction → w all 0; qd pulse → w2=1, not w1.
  - stop=1 in W2 with long=1 → halt with W3 held; resume → w3=1.
- **Single step:** step_mode=1, qd pulsed 4 times with normal instructions → exactly 4 × (W1,W2), halting after each; instr_cnt=4.
- **Held qd:**
  - qd held high across a stop → no restart until qd drops and rises again.
  - qd_rise while running → no effect on beats.
- **Counter wrap:** 256 short instructions from instr_cnt=0 → instr_cnt=0 again. instr_done pulses 256 times, each exactly one period wide.
